// File: rtl/dffn_stim_pkg.sv
`default_nettype none
// ============================================================================
// dffn_stim_pkg: types, constants and phase-offset helpers for dffn_stim_checker
// Rev 1.0
// ============================================================================
package dffn_stim_pkg;

  localparam int          c_phase_w   = 16;
  localparam logic [15:0] c_lfsr_poly = 16'hB400;  // x^16+x^14+x^13+x^11+1, right-shifting

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    STEP_RST      = 4'd1,
    STEP_SET      = 4'd2,
    STEP_BOTH     = 4'd3,
    STEP_REL_RN   = 4'd4,
    STEP_REL_SETN = 4'd5,
    STEP_CAPTURE  = 4'd6,
    STEP_ASYNC    = 4'd7
  } step_t;

  function automatic logic in_first_half(input logic [c_phase_w-1:0] phase,
                                         input logic [c_phase_w-1:0] half);
    return phase < half;
  endfunction

  function automatic logic is_first_cmp(input logic [c_phase_w-1:0] phase,
                                        input logic [c_phase_w-1:0] settle);
    return phase == settle;
  endfunction

  function automatic logic is_second_cmp(input logic [c_phase_w-1:0] phase,
                                         input logic [c_phase_w-1:0] half,
                                         input logic [c_phase_w-1:0] settle);
    return phase == (half + settle);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dffn_stim_lfsr.sv
`default_nettype none
// ============================================================================
// dffn_stim_lfsr: 16-bit right-shifting Galois LFSR with seed load and advance
// Rev 1.0
// ============================================================================
module dffn_stim_lfsr
  import dffn_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_adv,
  output logic        o_next_bit
);

  logic [15:0] r_state;
  logic [15:0] w_next;

  always_comb begin
    w_next = {1'b0, r_state[15:1]} ^ (r_state[0] ? c_lfsr_poly : 16'h0000);
  end

  // An all-zero seed would lock the register, so it is replaced by 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= 16'h0001;
    end else if (i_load) begin
      r_state <= (i_seed == 16'h0000) ? 16'h0001 : i_seed;
    end else if (i_adv) begin
      r_state <= w_next;
    end
  end

  assign o_next_bit = w_next[0];

endmodule
`default_nettype wire

// File: rtl/dffn_stim_checker.sv
`default_nettype none
// ============================================================================
// dffn_stim_checker: drives and checks one negative-edge flop with async SETN/RN
// Rev 1.0
// ============================================================================
module dffn_stim_checker
  import dffn_stim_pkg::*;
#(
  parameter int          HALF_PERIOD = 4,
  parameter int          SETTLE      = 2,
  parameter int          ITER        = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic        BOTH_LOW_Q  = 1'b0
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_step,
  output logic [7:0] err_count,
  output logic       dut_clkn,
  output logic       dut_d,
  output logic       dut_setn,
  output logic       dut_rn,
  input  logic       dut_q
);

  localparam logic [15:0] c_half      = 16'(HALF_PERIOD);
  localparam logic [15:0] c_settle    = 16'(SETTLE);
  localparam logic [15:0] c_last      = 16'(2 * HALF_PERIOD - 1);
  localparam logic [7:0]  c_iter_last = 8'(ITER - 1);

  state_t      r_state, w_state_nxt;
  step_t       r_step, w_step_nxt;
  logic [15:0] r_phase, w_phase_nxt;
  logic [7:0]  r_iter, w_iter_nxt;
  logic        r_tail, w_tail_nxt;
  logic        w_accept;

  logic        r_clkn, r_d, r_setn, r_rn;
  logic        w_clkn_nxt, w_d_nxt, w_setn_nxt, w_rn_nxt;
  logic        w_adv, w_lfsr_bit;

  logic        r_q, r_hold;
  logic [7:0]  r_err;
  logic [3:0]  r_fail;
  logic        w_first, w_second, w_cmp_en, w_exp, w_cap_latch, w_mismatch;

  dffn_stim_lfsr u_lfsr (
    .clk        (CLK),
    .rst_n      (RN),
    .i_load     (w_accept),
    .i_seed     (LFSR_SEED),
    .i_adv      (w_adv),
    .o_next_bit (w_lfsr_bit)
  );

  // A trailing phase after ASYNC parks the drives at their idle levels
  // before done rises, so a run spans 7+ITER phases.
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_phase_nxt = r_phase;
    w_iter_nxt  = r_iter;
    w_tail_nxt  = r_tail;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
          w_step_nxt  = STEP_RST;
          w_phase_nxt = '0;
          w_iter_nxt  = '0;
          w_tail_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        if (r_phase != c_last) begin
          w_phase_nxt = r_phase + 16'd1;
        end else begin
          w_phase_nxt = '0;
          if (r_tail) begin
            w_state_nxt = ST_DONE;
          end else begin
            case (r_step)
              STEP_CAPTURE: begin
                if (r_iter == c_iter_last) w_step_nxt = STEP_ASYNC;
                else                       w_iter_nxt = r_iter + 8'd1;
              end
              STEP_ASYNC: w_tail_nxt = 1'b1;
              default:    w_step_nxt = step_t'(r_step + 4'd1);
            endcase
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= ST_IDLE;
      r_step  <= STEP_RST;
      r_phase <= '0;
      r_iter  <= '0;
      r_tail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_phase <= w_phase_nxt;
      r_iter  <= w_iter_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  // Drives are decoded from the next step/offset so they change on the edge that begins it.
  always_comb begin
    w_clkn_nxt = 1'b1;
    w_setn_nxt = 1'b1;
    w_rn_nxt   = 1'b1;
    w_d_nxt    = w_accept ? 1'b0 : r_d;
    w_adv      = 1'b0;
    case (w_state_nxt)
      ST_IDLE: w_rn_nxt = 1'b0;
      ST_RUN: begin
        if (!w_tail_nxt) begin
          case (w_step_nxt)
            STEP_RST:    w_rn_nxt = 1'b0;
            STEP_SET:    w_setn_nxt = 1'b0;
            STEP_BOTH: begin
              w_rn_nxt   = 1'b0;
              w_setn_nxt = 1'b0;
            end
            STEP_REL_RN: w_setn_nxt = 1'b0;
            STEP_CAPTURE: begin
              w_clkn_nxt = in_first_half(w_phase_nxt, c_half);
              if (w_phase_nxt == '0) begin
                w_adv   = 1'b1;
                w_d_nxt = w_lfsr_bit;
              end
            end
            STEP_ASYNC: begin
              w_clkn_nxt = 1'b0;
              w_rn_nxt   = !in_first_half(w_phase_nxt, c_half);
            end
            default: begin end
          endcase
        end
      end
      default: begin end
    endcase
  end

  always_comb begin
    w_first     = is_first_cmp(r_phase, c_settle);
    w_second    = is_second_cmp(r_phase, c_half, c_settle);
    w_cmp_en    = 1'b0;
    w_exp       = 1'b0;
    w_cap_latch = 1'b0;
    if (r_state == ST_RUN && !r_tail) begin
      case (r_step)
        STEP_RST:                            w_cmp_en = w_first;
        STEP_SET, STEP_REL_RN, STEP_REL_SETN: begin
          w_cmp_en = w_first;
          w_exp    = 1'b1;
        end
        STEP_BOTH: begin
          w_cmp_en = w_first;
          w_exp    = BOTH_LOW_Q;
        end
        STEP_CAPTURE: begin
          w_cmp_en    = w_first | w_second;
          w_exp       = w_second ? r_d : r_hold;
          w_cap_latch = w_second;
        end
        STEP_ASYNC:                          w_cmp_en = w_first | w_second;
        default: begin end
      endcase
    end
    w_mismatch = w_cmp_en && (r_q != w_exp);
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_clkn <= 1'b1;
      r_d    <= 1'b0;
      r_setn <= 1'b1;
      r_rn   <= 1'b0;
      r_q    <= 1'b0;
      r_hold <= 1'b1;
      r_err  <= '0;
      r_fail <= '0;
    end else begin
      r_clkn <= w_clkn_nxt;
      r_d    <= w_d_nxt;
      r_setn <= w_setn_nxt;
      r_rn   <= w_rn_nxt;
      r_q    <= dut_q;
      if (w_accept) begin
        r_err  <= '0;
        r_fail <= '0;
        r_hold <= 1'b1;
      end else begin
        if (w_mismatch) begin
          if (r_err != 8'hFF) r_err <= r_err + 8'd1;
          if (r_fail == 4'd0) r_fail <= r_step;
        end
        if (w_cap_latch) r_hold <= r_d;
      end
    end
  end

  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign pass      = done && (r_err == 8'd0);
  assign fail_step = r_fail;
  assign err_count = r_err;
  assign dut_clkn  = r_clkn;
  assign dut_d     = r_d;
  assign dut_setn  = r_setn;
  assign dut_rn    = r_rn;

endmodule
`default_nettype wire

// File: tb/tb_dffn_stim_checker.sv
`default_nettype none
// ============================================================================
// tb_dffn_stim_checker: two checker instances against behavioural flops with selectable faults
// Rev 1.0
// ============================================================================
module tb_dffn_stim_checker;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RN = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;

  logic       a_busy, a_done, a_pass, a_clkn, a_d, a_setn, a_rn, a_q;
  logic [3:0] a_fail;
  logic [7:0] a_err;
  logic       b_busy, b_done, b_pass, b_clkn, b_d, b_setn, b_rn, b_q;
  logic [3:0] b_fail;
  logic [7:0] b_err;

  dffn_stim_checker u_a (
    .CLK(CLK), .RN(RN), .start(start_a), .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail_step(a_fail), .err_count(a_err), .dut_clkn(a_clkn), .dut_d(a_d),
    .dut_setn(a_setn), .dut_rn(a_rn), .dut_q(a_q)
  );

  dffn_stim_checker #(
    .HALF_PERIOD(2), .SETTLE(1), .ITER(1), .LFSR_SEED(16'h0000), .BOTH_LOW_Q(1'b1)
  ) u_b (
    .CLK(CLK), .RN(RN), .start(start_b), .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail_step(b_fail), .err_count(b_err), .dut_clkn(b_clkn), .dut_d(b_d),
    .dut_setn(b_setn), .dut_rn(b_rn), .dut_q(b_q)
  );

  // Flop modes: 0 good (RN wins when both low), 1 Q stuck 0, 2 rising-edge capture, 3 SETN wins.
  int   mode_a = 0, mode_b = 3;
  logic qa = 1'b0, qb = 1'b0, pca = 1'b1, pcb = 1'b1;

  always @(a_clkn or a_rn or a_setn) begin
    if (!a_rn && !a_setn)  qa = (mode_a == 3);
    else if (!a_rn)        qa = 1'b0;
    else if (!a_setn)      qa = 1'b1;
    else if (mode_a == 2 ? (!pca && a_clkn) : (pca && !a_clkn)) qa = a_d;
    pca = a_clkn;
  end

  always @(b_clkn or b_rn or b_setn) begin
    if (!b_rn && !b_setn)  qb = (mode_b == 3);
    else if (!b_rn)        qb = 1'b0;
    else if (!b_setn)      qb = 1'b1;
    else if (mode_b == 2 ? (!pcb && b_clkn) : (pcb && !b_clkn)) qb = b_d;
    pcb = b_clkn;
  end

  assign a_q = (mode_a == 1) ? 1'b0 : qa;
  assign b_q = (mode_b == 1) ? 1'b0 : qb;

  bit sel = 1'b0;
  logic       w_busy, w_done, w_pass, w_clkn, w_d, w_setn, w_rn;
  logic [3:0] w_fail;
  logic [7:0] w_err;
  assign w_busy = sel ? b_busy : a_busy;
  assign w_done = sel ? b_done : a_done;
  assign w_pass = sel ? b_pass : a_pass;
  assign w_clkn = sel ? b_clkn : a_clkn;
  assign w_d    = sel ? b_d    : a_d;
  assign w_setn = sel ? b_setn : a_setn;
  assign w_rn   = sel ? b_rn   : a_rn;
  assign w_fail = sel ? b_fail : a_fail;
  assign w_err  = sel ? b_err  : a_err;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Run-level reference: list every compare as (step, expected Q, Q a flop of the given mode shows).
  int   m_err, m_fail;
  logic m_d[$];

  function automatic void note(input int step, input logic exp, input logic act, input int mode);
    logic a;
    a = (mode == 1) ? 1'b0 : act;
    if (a != exp) begin
      if (m_fail == 0) m_fail = step;
      if (m_err < 255) m_err++;
    end
  endfunction

  function automatic void model_run(input int iter, input logic [15:0] seed, input logic blq,
                                    input int mode);
    logic [15:0] s;
    logic        prev, d;
    m_err = 0;
    m_fail = 0;
    m_d.delete();
    s = (seed == 16'h0000) ? 16'h0001 : seed;
    note(1, 1'b0, 1'b0, mode);
    note(2, 1'b1, 1'b1, mode);
    note(3, blq, (mode == 3), mode);
    note(4, 1'b1, 1'b1, mode);
    note(5, 1'b1, 1'b1, mode);
    prev = 1'b1;
    for (int i = 0; i < iter; i++) begin
      s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
      d = s[0];
      m_d.push_back(d);
      note(6, prev, prev, mode);
      note(6, d, d, mode);
      prev = d;
    end
    note(7, 1'b0, 1'b0, mode);
    note(7, 1'b0, 1'b0, mode);
  endfunction

  typedef struct {
    int   cyc;
    logic clkn;
    logic setn;
    logic rn;
    logic busy;
  } vec_t;
  vec_t tbl[12];

  task automatic do_run(input bit s, input int iter, input int hp, input logic [15:0] seed,
                        input logic blq, input int mode, input bit use_tbl);
    int   total, len, nfall, c;
    logic pclk, pd, psetn, prn, st;
    total = (7 + iter) * 2 * hp;
    model_run(iter, seed, blq, mode);
    sel = s;
    if (s) mode_b = mode; else mode_a = mode;
    repeat ($urandom_range(1, 4)) @(posedge CLK);
    #1;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    pclk = w_clkn; pd = w_d; psetn = w_setn; prn = w_rn;
    @(posedge CLK); #1;
    c = 0; len = -1; nfall = 0;
    while (len < 0 && c <= total + 4 * hp) begin
      if (use_tbl) begin
        foreach (tbl[k]) begin
          if (tbl[k].cyc == c) begin
            chk($sformatf("tbl%0d_clkn", c), w_clkn, tbl[k].clkn);
            chk($sformatf("tbl%0d_setn", c), w_setn, tbl[k].setn);
            chk($sformatf("tbl%0d_rn", c),   w_rn,   tbl[k].rn);
            chk($sformatf("tbl%0d_busy", c), w_busy, tbl[k].busy);
          end
        end
      end
      if (w_done) len = c;
      if ((!psetn && w_setn) || (!prn && w_rn))
        chk("setn_rn_rise_together", int'(!psetn && w_setn && !prn && w_rn), 0);
      if (w_d !== pd)
        chk("d_change_window", int'({w_clkn, 1'((c % (2 * hp)) == 0)}), 3);
      if (pclk && !w_clkn && w_busy) begin
        if (nfall < m_d.size()) chk("dut_d_at_fall", w_d, m_d[nfall]);
        nfall++;
      end
      pclk = w_clkn; pd = w_d; psetn = w_setn; prn = w_rn;
      // Random start pulses while busy must be ignored, including one on the final edge.
      if (len >= 0)             st = 1'b0;
      else if (c + 1 == total)  st = 1'b1;
      else if (c + 1 < total)   st = 1'($urandom_range(0, 1));
      else                      st = 1'b0;
      if (s) start_b = st; else start_a = st;
      if (len < 0) begin
        @(posedge CLK); #1;
        c++;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk("run_length", len, total);
    chk("capture_falls", nfall, iter);
    if (mode == 2) begin
      chk("fail_step", w_fail, 6);
      chk("err_nonzero", int'(w_err != 8'd0), 1);
      chk("pass", w_pass, 0);
    end else begin
      chk("err_count", w_err, m_err);
      chk("fail_step", w_fail, m_fail);
      chk("pass", w_pass, int'(m_err == 0));
    end
    repeat ($urandom_range(1, 4)) begin
      @(posedge CLK); #1;
      chk("done_hold", w_done, 1);
    end
  endtask

  task automatic reset_mid_run();
    sel = 1'b0;
    mode_a = 0;
    @(posedge CLK); #1;
    start_a = 1'b1;
    @(posedge CLK); #1;
    start_a = 1'b0;
    repeat (49) @(posedge CLK);
    #1;
    RN = 1'b0;
    @(posedge CLK); #1;
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_rn",   a_rn,   0);
    chk("rst_mid_clkn", a_clkn, 1);
    chk("rst_mid_setn", a_setn, 1);
    chk("rst_mid_done", a_done, 0);
    chk("rst_mid_err",  a_err,  0);
    repeat (4) @(posedge CLK);
    #1;
    RN = 1'b1;
    repeat (6) begin
      @(posedge CLK); #1;
      chk("rst_mid_no_done", a_done, 0);
    end
  endtask

  initial begin
    tbl[0]  = '{0,   1'b1, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{7,   1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{8,   1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{16,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{24,  1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{32,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{43,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{44,  1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{48,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{167, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{168, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{172, 1'b0, 1'b1, 1'b1, 1'b1};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_fail_step", a_fail, 0);
    chk("rst_err_count", a_err, 0);
    chk("rst_clkn", a_clkn, 1);
    chk("rst_d", a_d, 0);
    chk("rst_setn", a_setn, 1);
    chk("rst_rn", a_rn, 0);
    chk("rst_b_rn", b_rn, 0);
    RN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("idle_no_done", a_done, 0);

    do_run(1'b0, 16, 4, 16'hACE1, 1'b0, 0, 1'b1);
    do_run(1'b0, 16, 4, 16'hACE1, 1'b0, 1, 1'b0);
    do_run(1'b0, 16, 4, 16'hACE1, 1'b0, 2, 1'b0);
    do_run(1'b0, 16, 4, 16'hACE1, 1'b0, 3, 1'b0);
    reset_mid_run();
    do_run(1'b0, 16, 4, 16'hACE1, 1'b0, 0, 1'b1);
    do_run(1'b1, 1, 2, 16'h0000, 1'b1, 3, 1'b0);
    do_run(1'b1, 1, 2, 16'h0000, 1'b1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
